mips_regfile_mp: RTL and testbench

//  Parametrised multi-port GPR file for the 4/8-stage pipeline cores. NUM_RD read ports with same-cycle

---
 rtl/mips_regfile_mp_pkg.sv | 19 +
 rtl/mips_regfile_mp_bypass_mux.sv | 37 +++
 rtl/mips_regfile_mp.sv | 104 ++++++++++
 tb/tb_mips_regfile_mp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_regfile_mp_pkg.sv
// Shared constants for the multi-port GPR file: architectural register
// indices and the default $gp/$sp reset values.
package mips_regfile_mp_pkg;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_GP   = 28;
   localparam int unsigned REG_SP   = 29;

   localparam logic [31:0] GP_RST_DEF = 32'h0000_1800;
   localparam logic [31:0] SP_RST_DEF = 32'h0000_2ffc;

   // True when an enabled write port targets a real (non-zero) register
   // that matches the given read address.
   function automatic logic wr_match(input logic en, input logic [31:0] wa,
                                     input logic [31:0] ra);
      return en && (wa == ra) && (ra != 32'(REG_ZERO));
   endfunction

endpackage

// File: rtl/mips_regfile_mp_bypass_mux.sv
// One read port of the GPR file: selects the youngest same-cycle write
// data that targets the read address, otherwise the stored value.
// Register 0 always reads as zero and never reports a hit.
module rf_bypass_mux
   import mips_regfile_mp_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned NUM_WR = 2
) (
   input  logic [ADDR_W-1:0]        ra,
   input  logic [DATA_W-1:0]        stored,
   input  logic [NUM_WR-1:0]        we,
   input  logic [NUM_WR*ADDR_W-1:0] wa,
   input  logic [NUM_WR*DATA_W-1:0] wd,
   output logic [DATA_W-1:0]        rd,
   output logic                     hit
);

   // Ascending scan: a later (higher-index) match overrides earlier ones,
   // so the youngest writer wins.
   always_comb begin
      rd  = stored;
      hit = 1'b0;
      if (ra == ADDR_W'(REG_ZERO)) begin
         rd = '0;
      end else begin
         for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_match(we[k], 32'(wa[k*ADDR_W +: ADDR_W]), 32'(ra))) begin
               rd  = wd[k*DATA_W +: DATA_W];
               hit = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS general-purpose register file with same-cycle
// write-to-read bypass, fixed write-port priority (higher index wins) and
// a per-register busy scoreboard for ID-stage hazard detection.
module mips_regfile_mp
   import mips_regfile_mp_pkg::*;
#(
   parameter int unsigned       DATA_W = 32,
   parameter int unsigned       ADDR_W = 5,
   parameter int unsigned       NUM_RD = 2,
   parameter int unsigned       NUM_WR = 2,
   parameter int unsigned       GP_IDX = REG_GP,
   parameter int unsigned       SP_IDX = REG_SP,
   parameter logic [DATA_W-1:0] GP_RST = DATA_W'(GP_RST_DEF),
   parameter logic [DATA_W-1:0] SP_RST = DATA_W'(SP_RST_DEF)
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [NUM_WR-1:0]        We,
   input  logic [NUM_WR*ADDR_W-1:0] WA,
   input  logic [NUM_WR*DATA_W-1:0] WD,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic [NUM_RD-1:0]        RBusy,
   input  logic                     IssueWe,
   input  logic [ADDR_W-1:0]        IssueA,
   input  logic                     Flush
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_set;
   logic [DEPTH-1:0]  busy_clr;
   logic [NUM_RD-1:0] hit;

   // Register storage: reset loads $gp/$sp, writes applied in ascending
   // port order so the highest enabled port to a given address lands last.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         regs[GP_IDX] <= GP_RST;
         regs[SP_IDX] <= SP_RST;
      end else begin
         for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (We[k] && (WA[k*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
               regs[WA[k*ADDR_W +: ADDR_W]] <= WD[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Scoreboard decode: issue marks its destination, any writeback clears.
   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (IssueWe && (IssueA != ADDR_W'(REG_ZERO))) begin
         busy_set[IssueA] = 1'b1;
      end
      for (int unsigned k = 0; k < NUM_WR; k++) begin
         if (We[k]) begin
            busy_clr[WA[k*ADDR_W +: ADDR_W]] = 1'b1;
         end
      end
   end

   // Scoreboard state: flush wipes everything; a set in the same cycle as
   // a clear wins because the newly issued writer is still outstanding.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         busy <= '0;
      end else if (Flush) begin
         busy <= '0;
      end else begin
         busy <= busy_set | (busy & ~busy_clr);
      end
   end

   // Read ports: bypass mux per port; a bypass hit satisfies the reader even
   // though the busy bit only drops at the next edge.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      assign ra = RA[p*ADDR_W +: ADDR_W];

      rf_bypass_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_mux (
         .ra     (ra),
         .stored (regs[ra]),
         .we     (We),
         .wa     (WA),
         .wd     (WD),
         .rd     (RD[p*DATA_W +: DATA_W]),
         .hit    (hit[p])
      );

      assign RBusy[p] = busy[ra] && !hit[p] && (ra != ADDR_W'(REG_ZERO));
   end

endmodule

// File: tb/tb_mips_regfile_mp.sv
// Randomised and directed scoreboard bench for mips_regfile_mp.
module tb_mips_regfile_mp;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [1:0]  We;
   logic [9:0]  WA;
   logic [63:0] WD;
   logic [9:0]  RA;
   logic [63:0] RD;
   logic [1:0]  RBusy;
   logic        IssueWe;
   logic [4:0]  IssueA;
   logic        Flush;

   logic [4:0]  wa_v [2];
   logic [31:0] wd_v [2];
   logic [4:0]  ra_v [2];

   assign WA = {wa_v[1], wa_v[0]};
   assign WD = {wd_v[1], wd_v[0]};
   assign RA = {ra_v[1], ra_v[0]};

   always #5 Clk = ~Clk;

   mips_regfile_mp #(
      .DATA_W (32),
      .ADDR_W (5),
      .NUM_RD (2),
      .NUM_WR (2)
   ) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .We      (We),
      .WA      (WA),
      .WD      (WD),
      .RA      (RA),
      .RD      (RD),
      .RBusy   (RBusy),
      .IssueWe (IssueWe),
      .IssueA  (IssueA),
      .Flush   (Flush)
   );

   typedef struct {
      string       nm;
      logic [31:0] rd [2];
      logic        rb [2];
   } exp_t;

   exp_t        scb [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   // Reference model: architectural register contents and outstanding writers.
   logic [31:0] m_mem [32];
   bit   [31:0] m_busy;

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      m_mem[28] = 32'h0000_1800;
      m_mem[29] = 32'h0000_2ffc;
      m_busy = '0;
   endtask

   task automatic idle();
      We = 2'b00; IssueWe = 1'b0; IssueA = 5'd0; Flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         wa_v[k] = 5'd0; wd_v[k] = 32'h0; ra_v[k] = 5'd0;
      end
   endtask

   // Predict what the reader should see with the inputs currently applied,
   // queue it, then advance the model across the next rising edge.
   task automatic step(input string nm);
      exp_t        e;
      logic [31:0] val;
      bit          hit;
      bit   [31:0] nb;
      if (Rst) model_reset();
      e.nm = nm;
      for (int p = 0; p < 2; p++) begin
         hit = 0;
         val = m_mem[ra_v[p]];
         for (int k = 0; k < 2; k++) begin
            if (We[k] && wa_v[k] == ra_v[p]) begin
               hit = 1;
               val = wd_v[k];
            end
         end
         if (ra_v[p] == 5'd0) begin
            e.rd[p] = 32'h0;
            e.rb[p] = 1'b0;
         end else begin
            e.rd[p] = val;
            e.rb[p] = m_busy[ra_v[p]] && !hit;
         end
      end
      scb.push_back(e);
      @(posedge Clk);
      if (!Rst) begin
         for (int k = 0; k < 2; k++)
            if (We[k] && wa_v[k] != 5'd0) m_mem[wa_v[k]] = wd_v[k];
         if (Flush) begin
            m_busy = '0;
         end else begin
            nb = m_busy;
            for (int k = 0; k < 2; k++) if (We[k]) nb[wa_v[k]] = 1'b0;
            if (IssueWe && IssueA != 5'd0) nb[IssueA] = 1'b1;
            m_busy = nb;
         end
      end
      #2;
   endtask

   function automatic logic [4:0] pick_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8) return 5'(r);
      else if (r == 8) return 5'd28;
      else return 5'd29;
   endfunction

   // Monitor: outputs settle between the input drive and the next rising
   // edge; compare on the falling edge against the queued prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge Clk);
         if (scb.size() > 0) begin
            e = scb.pop_front();
            for (int p = 0; p < 2; p++) begin
               n_tests++;
               if (RD[p*32 +: 32] !== e.rd[p]) begin
                  n_fail++;
                  $display("FAIL %s rd%0d: got %h want %h", e.nm, p, RD[p*32 +: 32], e.rd[p]);
               end
               n_tests++;
               if (RBusy[p] !== e.rb[p]) begin
                  n_fail++;
                  $display("FAIL %s rbusy%0d: got %b want %b", e.nm, p, RBusy[p], e.rb[p]);
               end
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      Rst = 1'b1;
      idle();
      model_reset();
      @(posedge Clk);
      #2;

      // Reset contents visible while reset is held
      ra_v[0] = 5'd28; ra_v[1] = 5'd29;
      step("reset_gp_sp");
      ra_v[0] = 5'd5;  ra_v[1] = 5'd0;
      step("reset_r5");
      Rst = 1'b0;

      // Same-cycle bypass, then from storage
      idle();
      We = 2'b01; wa_v[0] = 5'd7; wd_v[0] = 32'hDEAD_BEEF; ra_v[0] = 5'd7;
      step("bypass");
      idle(); ra_v[0] = 5'd7;
      step("stored7");

      // Write-port priority
      idle();
      We = 2'b11; wa_v[0] = 5'd9; wa_v[1] = 5'd9;
      wd_v[0] = 32'h1111_1111; wd_v[1] = 32'h2222_2222;
      ra_v[0] = 5'd9; ra_v[1] = 5'd9;
      step("prio_bypass");
      idle(); ra_v[0] = 5'd9; ra_v[1] = 5'd9;
      step("prio_stored");

      // Register zero
      idle();
      We = 2'b10; wa_v[1] = 5'd0; wd_v[1] = 32'hFFFF_FFFF;
      IssueWe = 1'b1; IssueA = 5'd0;
      step("zero_now");
      idle();
      step("zero_after");

      // Scoreboard
      idle(); IssueWe = 1'b1; IssueA = 5'd12; ra_v[0] = 5'd12;
      step("sb_issue");
      idle(); ra_v[0] = 5'd12;
      step("sb_busy");
      idle(); We = 2'b01; wa_v[0] = 5'd12; wd_v[0] = 32'h0000_0C0C; ra_v[0] = 5'd12;
      step("sb_wb_bypass");
      idle(); ra_v[0] = 5'd12;
      step("sb_cleared");
      idle(); IssueWe = 1'b1; IssueA = 5'd12;
      step("sb_reissue");
      idle(); IssueWe = 1'b1; IssueA = 5'd12;
      We = 2'b10; wa_v[1] = 5'd12; wd_v[1] = 32'h1234_5678; ra_v[1] = 5'd12;
      step("sb_set_and_clr");
      idle(); ra_v[0] = 5'd12; ra_v[1] = 5'd12;
      step("sb_set_wins");
      idle(); Flush = 1'b1; IssueWe = 1'b1; IssueA = 5'd13; ra_v[0] = 5'd12;
      step("sb_flush");
      idle(); ra_v[0] = 5'd12; ra_v[1] = 5'd13;
      step("sb_after_flush");

      // Asynchronous reset mid-stream
      idle();
      We = 2'b11; wa_v[0] = 5'd3; wd_v[0] = 32'hA5A5_0003;
      wa_v[1] = 5'd12; wd_v[1] = 32'h5A5A_000C;
      IssueWe = 1'b1; IssueA = 5'd12;
      step("pre_rst_write");
      idle(); ra_v[0] = 5'd3; ra_v[1] = 5'd12;
      step("pre_rst_read");
      Rst = 1'b1;
      step("async_rst");
      Rst = 1'b0;
      step("post_rst");

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         Rst     = ($urandom_range(0, 99) < 2);
         We      = 2'($urandom_range(0, 3));
         IssueWe = ($urandom_range(0, 99) < 35);
         IssueA  = pick_addr();
         Flush   = ($urandom_range(0, 99) < 5);
         for (int k = 0; k < 2; k++) begin
            wa_v[k] = pick_addr();
            wd_v[k] = $urandom;
            ra_v[k] = pick_addr();
         end
         step("random");
      end
      Rst = 1'b0;
      idle();

      @(negedge Clk);
      #1;
      n_tests++;
      if (scb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending want 0", scb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
